// File: rtl/mul_32_seq.sv
// mul_32_seq: sequential signed radix-4 Booth multiplier, one digit per cycle, start/busy/done handshake.
// Define MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier digits are all zero.
module mul_32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int DIGITS = WIDTH / 2;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int P = 2 * WIDTH + 2;
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_next;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH:0] q_reg;
    logic [CW-1:0] count;
    logic signed [P-1:0] acc, acc_sum, acc_next;
    logic signed [WIDTH+1:0] m_ext, pp;
    logic [2*WIDTH-1:0] product;
    logic [2:0] bits;
    logic last;
    assign busy = (state == RUN);
    always_comb begin
        m_ext = {{2{m_reg[WIDTH-1]}}, m_reg};
        bits = q_reg[2:0];
        pp = (bits == 3'b001 || bits == 3'b010) ? m_ext :
             (bits == 3'b011) ? m_ext <<< 1 :
             (bits == 3'b100) ? -(m_ext <<< 1) :
             (bits == 3'b101 || bits == 3'b110) ? -m_ext : '0;
        // Partial products enter at the top; the shift right walks them to their weight.
        acc_sum = acc + {pp, {WIDTH{1'b0}}};
        acc_next = acc_sum >>> 2;
`ifdef MUL_EARLY_TERM_EN
        last = (&q_reg[WIDTH:2]) | ~(|q_reg[WIDTH:2]);
        product = (2*WIDTH)'(acc_next >>> (2 * (DIGITS - 1 - int'(count))));
`else
        last = (count == CW'(DIGITS - 1));
        product = acc_next[2*WIDTH-1:0];
`endif
    end
    always_comb begin
        state_next = state;
        if (state == IDLE) state_next = start ? RUN : IDLE;
        else state_next = last ? IDLE : RUN;
    end
    always_ff @(posedge clock) begin
        if (clear) state <= IDLE;
        else state <= state_next;
    end
    always_ff @(posedge clock) begin
        if (clear) begin
            m_reg <= '0;
            q_reg <= '0;
            count <= '0;
            acc <= '0;
            done <= 1'b0;
            hi <= '0;
            lo <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                m_reg <= multiplicand;
                q_reg <= {multiplier, 1'b0};
                count <= '0;
                acc <= '0;
            end else if (state == RUN) begin
                acc <= acc_next;
                q_reg <= $signed(q_reg) >>> 2;
                count <= count + 1'b1;
                if (last) begin
                    done <= 1'b1;
                    hi <= product[2*WIDTH-1:WIDTH];
                    lo <= product[WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: doc/mul_32_seq.md
Name: mul_32_seq

Overview:
- Sequential signed 32x32 multiplier using radix-4 Booth (bit-pair) recoding; produces a 64-bit product split into HI/LO words.
- Companion to the datapath's 32-bit divider: performs the inverse operation for the MUL instruction and feeds the HI/LO registers.
- Handshake is start/busy/done, so the control unit stalls on busy instead of relying on a long combinational path.

Parameters:
- WIDTH, 32, operand width; must be even. Digits per operation = WIDTH/2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- clear  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while idle.
- multiplicand  input  WIDTH  signed operand M; captured on accepted start.
- multiplier  input  WIDTH  signed operand Q; captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; product valid.
- hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH].
- lo  output  WIDTH  product bits [WIDTH-1:0].

Behaviour:
- Reset: clear=1 at an edge forces IDLE with busy=0, done=0, hi=0, lo=0, and all internal registers zeroed. Clear has priority over start and applies mid-operation; the current operation is abandoned and produces no done.
- States: IDLE, RUN.
- IDLE:
  - start=1 at edge E0 latches M and Q, sets digit count=0, clears the accumulator, and enters RUN; busy=1 from E0.
  - start=0 leaves the block in IDLE.
- RUN:
  - Each edge processes one Booth digit from multiplier bits (2i+1, 2i, 2i-1), with bit -1 = 0.
  - Digit encoding: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - Partial products are formed at 2*WIDTH+2 bits internally, with M sign-extended before doubling, so -2^31 and 2M are exact.
  - Weighting: either add at offset 2i, or add to the top and arithmetic-shift right 2 per cycle. Both are allowed; the result must be bit-exact.
  - After the 16th digit (edge E16): {hi,lo} = full signed product, done=1 for exactly one cycle, busy=0, return to IDLE.
  - Latency: start accepted at E0 -> done high in the cycle after E16 (16 cycles). Back-to-back start is accepted at the edge where done is high (E17 earliest).
- start while busy: ignored; the latched operands are unaffected by input changes during RUN.
- hi/lo hold their last product until the next done or clear; they do not change at start.
- Result is mod 2^64 two's complement. No overflow is possible: 64 bits hold every 32x32 signed product.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined:
  - The operation ends after k digits, where k = the smallest value in 1..16 such that multiplier bits [31:2k-1] are all equal.
  - Once those remaining bits are all equal, every remaining digit is 0; the accumulator is aligned, i.e. arithmetic-shifted by 2*(16-k) if the shift scheme is used.
  - done occurs in the cycle after edge Ek.
  - Examples: Q=0 or Q=-1 gives k=1; Q=5 gives k=2; Q=0x7FFFFFFF gives k=16.
  - Product values are identical to the undefined build.
- Undefined: fixed 16-digit latency for every operand; no extra logic.

Test Plan:
- Reset/idle: clear=1 for 2 cycles, then hold start=0 for 5 cycles -> busy=0, done=0, hi=0, lo=0 throughout.
- Basic signed: M=-7, Q=3, start for one cycle -> done exactly 16 cycles after the accepting edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 16 cycles.
- Extremes:
  - M=Q=0x80000000 -> hi=0x40000000, lo=0x00000000.
  - M=Q=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
  - M=0x80000000, Q=0x7FFFFFFF -> hi=0xC0000000, lo=0x80000000.
- Handshake:
  - Pulse start (M=2, Q=3); at cycle 5 assert start with M=9, Q=9 -> second start is ignored, result hi=0, lo=6.
  - Start again in the done cycle (M=-1, Q=-1) -> accepted; next result hi=0, lo=1.
- Clear mid-operation: start M=100, Q=100; clear at cycle 8 -> no done pulse, hi=lo=0, busy=0. A new start then gives lo=10000 after 16 cycles.
- MUL_EARLY_TERM_EN build:
  - M=1234, Q=0 -> done after 1 cycle, hi=lo=0.
  - M=7, Q=-3 -> done after 2 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - M=-1, Q=0x7FFFFFFF -> done after 16 cycles, hi=0xFFFFFFFF, lo=0x80000001.
